// File: rtl/pipe_share_sched_pkg.sv
// Shared types and helpers for the round-robin pipe-sharing scheduler.
package pipe_share_sched_pkg;

  // Ceiling log2 with a floor of 1 bit, so a 2-entry tag still has a bit.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      w++;
    end
    return (w < 1) ? 1 : w;
  endfunction

  // Tag storage is sized for the largest supported channel count; the
  // scheduler only ever writes the low clog2(NUM_REQ) bits.
  localparam int TAG_W_MAX = 8;

  typedef logic [TAG_W_MAX-1:0] tag_t;

  // One slot of the tag line that travels alongside the shared pipe.
  typedef struct packed {
    logic valid;
    tag_t tag;
  } stage_t;

endpackage

// File: rtl/pipe_share_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first eligible channel at or after ptr.
// Purely combinational; the scheduler owns the pointer register.
module rr_arbiter
  import pipe_share_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int TAG_W = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [TAG_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [TAG_W-1:0]   grant_idx,
  output logic               grant_any
);

  // Walk ptr, ptr+1, ... (mod NUM_REQ) and take the first eligible channel.
  always_comb begin
    int j;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    j         = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(ptr) + i) % NUM_REQ;
      if (!grant_any && eligible[j]) begin
        grant[j]  = 1'b1;
        grant_idx = TAG_W'(j);
        grant_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_share_sched.sv
// Shares one fixed-latency pipe among NUM_REQ channels. Issues at most one
// operand per clock in round-robin order, carries the owner tag alongside the
// pipe and steers each returning result back to its channel.
//
// Handshake: a channel raises req[i] with req_data held stable; the operand
// transfers on the rising edge where ack[i]=1 (ack is combinational). req may
// stay high for back-to-back issue. Results have no backpressure: res_valid is
// a single-cycle one-hot strobe with res_data valid in the same cycle.
module pipe_share_sched
  import pipe_share_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16,
  parameter int DELAY   = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]       chan_en,
  input  logic                     flush,
  output logic [NUM_REQ-1:0]       ack,
  output logic [WIDTH-1:0]         pipe_in,
  output logic                     pipe_in_valid,
  input  logic [WIDTH-1:0]         pipe_out,
  output logic [NUM_REQ-1:0]       res_valid,
  output logic [WIDTH-1:0]         res_data,
  output logic                     busy
);

  localparam int TAG_W = clog2(NUM_REQ);

  logic [TAG_W-1:0]   ptr;
  logic [TAG_W-1:0]   next_ptr;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant_oh;
  logic [TAG_W-1:0]   grant_idx;
  logic               grant_any;
  logic               take;
  logic [WIDTH-1:0]   sel_data;
  logic [NUM_REQ-1:0] res_onehot;

  // Stage 0 of the tag line is the issue register; stages 1..DELAY follow
  // the operand through the shared pipe.
  stage_t             issue_q;
  stage_t [DELAY:1]   line_q;

  assign eligible = req & chan_en;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .eligible  (eligible),
    .ptr       (ptr),
    .grant     (grant_oh),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // A grant is only taken outside reset and when no flush is pending.
  assign take     = grant_any & reset & ~flush;
  assign ack      = take ? grant_oh : '0;
  assign sel_data = req_data[int'(grant_idx)*WIDTH +: WIDTH];
  assign next_ptr = (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  assign pipe_in_valid = issue_q.valid;
  assign res_onehot    = NUM_REQ'(1) << line_q[DELAY].tag;

  // Issue register: latch the winning operand and advance the pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr     <= '0;
      pipe_in <= '0;
      issue_q <= '0;
    end else if (flush) begin
      ptr           <= '0;
      issue_q.valid <= 1'b0;
    end else if (take) begin
      ptr     <= next_ptr;
      pipe_in <= sel_data;
      issue_q <= '{valid: 1'b1, tag: tag_t'(grant_idx)};
    end else begin
      issue_q.valid <= 1'b0;
    end
  end

  // Tag line: shift owner tags in lock-step with the shared pipe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      line_q <= '0;
    end else if (flush) begin
      line_q <= '0;
    end else begin
      line_q[1] <= issue_q;
      for (int k = 2; k <= DELAY; k++) begin
        line_q[k] <= line_q[k-1];
      end
    end
  end

  // Result register: capture pipe_out and strobe the owning channel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_valid <= '0;
      res_data  <= '0;
    end else if (flush) begin
      res_valid <= '0;
    end else if (line_q[DELAY].valid) begin
      res_valid <= res_onehot;
      res_data  <= pipe_out;
    end else begin
      res_valid <= '0;
    end
  end

  // Busy while any slot of the tag line (including issue) holds live work.
  always_comb begin
    busy = issue_q.valid;
    for (int k = 1; k <= DELAY; k++) begin
      busy = busy | line_q[k].valid;
    end
  end

endmodule

// File: tb/tb_pipe_share_sched.sv
// Self-checking bench for pipe_share_sched: directed scenarios plus random
// traffic, checked against a transaction-level round-robin model.
module tb_pipe_share_sched;

  localparam int N = 4;
  localparam int W = 16;
  localparam int D = 3;

  // ---------------- clock / reset ----------------
  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   chan_en;
  logic           flush;
  logic [N-1:0]   ack;
  logic [W-1:0]   pipe_in;
  logic           pipe_in_valid;
  logic [W-1:0]   pipe_out;
  logic [N-1:0]   res_valid;
  logic [W-1:0]   res_data;
  logic           busy;

  always #5 clk = ~clk;

  pipe_share_sched #(.NUM_REQ(N), .WIDTH(W), .DELAY(D)) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .req_data      (req_data),
    .chan_en       (chan_en),
    .flush         (flush),
    .ack           (ack),
    .pipe_in       (pipe_in),
    .pipe_in_valid (pipe_in_valid),
    .pipe_out      (pipe_out),
    .res_valid     (res_valid),
    .res_data      (res_data),
    .busy          (busy)
  );

  // Shared pipe stand-in: D-clock register chain.
  logic [W-1:0] pipe_sr [D];
  initial for (int k = 0; k < D; k++) pipe_sr[k] = '0;
  always @(posedge clk) begin
    pipe_sr[0] <= pipe_in;
    for (int k = 1; k < D; k++) pipe_sr[k] <= pipe_sr[k-1];
  end
  assign pipe_out = pipe_sr[D-1];

  // ---------------- scoreboard / model state ----------------
  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  int           mptr     = 0;
  bit           pending [N];
  logic [W-1:0] pdata   [N];
  logic [W-1:0] exp_q[$];
  int           due_q[$];
  int           ch_q[$];
  logic [W-1:0] exp_pipe_in = '0;
  logic [W-1:0] last_res    = '0;
  bit           exp_piv     = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req[i]            = pending[i];
      req_data[i*W +: W] = pdata[i];
    end
  endtask

  // Idle channels start a new request with probability pct percent.
  task automatic refill(input int pct);
    for (int i = 0; i < N; i++) begin
      if (!pending[i] && ($urandom_range(0, 99) < pct)) begin
        pending[i] = 1'b1;
        pdata[i]   = W'($urandom);
      end
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    due_q.delete();
    ch_q.delete();
  endtask

  // One clock: check ack, take the edge, update model, check registered outputs.
  task automatic run_cycle();
    logic [N-1:0] elig;
    logic [N-1:0] exp_ack;
    int           w;
    int           c;
    drive();
    #1;
    elig = req & chan_en;
    w    = -1;
    for (int k = 0; k < N; k++) begin
      c = (mptr + k) % N;
      if (w < 0 && elig[c]) w = c;
    end
    exp_ack = (w >= 0 && !flush) ? N'(1 << w) : '0;
    check("ack", 32'(ack), 32'(exp_ack));

    @(posedge clk);
    cyc++;
    if (flush) begin
      model_clear();
      mptr    = 0;
      exp_piv = 1'b0;
    end else if (w >= 0) begin
      exp_q.push_back(pdata[w]);
      due_q.push_back(cyc + D + 1);
      ch_q.push_back(w);
      exp_pipe_in = pdata[w];
      exp_piv     = 1'b1;
      mptr        = (w + 1) % N;
      pending[w]  = 1'b0;
    end else begin
      exp_piv = 1'b0;
    end

    @(negedge clk);
    check("pipe_in_valid", 32'(pipe_in_valid), 32'(exp_piv));
    check("pipe_in", 32'(pipe_in), 32'(exp_pipe_in));
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      check("res_valid", 32'(res_valid), 32'(1 << ch_q[0]));
      check("res_data", 32'(res_data), 32'(exp_q[0]));
      last_res = exp_q[0];
      void'(exp_q.pop_front());
      void'(due_q.pop_front());
      void'(ch_q.pop_front());
    end else begin
      check("res_valid_idle", 32'(res_valid), 32'd0);
      check("res_data_hold", 32'(res_data), 32'(last_res));
    end
    check("busy", 32'(busy), 32'(due_q.size() > 0));
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ack"}, 32'(ack), 32'd0);
    check({tag, "_pipe_in_valid"}, 32'(pipe_in_valid), 32'd0);
    check({tag, "_pipe_in"}, 32'(pipe_in), 32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_res_data"}, 32'(res_data), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Assert reset between edges, check async clear, hold, release at negedge.
  task automatic do_reset();
    #2;
    reset = 1'b0;
    #1;
    check_zero_outputs("reset");
    model_clear();
    mptr        = 0;
    exp_pipe_in = '0;
    last_res    = '0;
    exp_piv     = 1'b0;
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    drive();
    #1;
    check("reset_hold_ack", 32'(ack), 32'd0);
    check("reset_hold_busy", 32'(busy), 32'd0);
    reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset   = 1'b1;
    flush   = 1'b0;
    chan_en = '1;
    req     = '0;
    req_data = '0;
    for (int i = 0; i < N; i++) begin
      pending[i] = 1'b0;
      pdata[i]   = '0;
    end

    // Power-on reset with a request already pending: ack must stay 0.
    @(negedge clk);
    pending[2] = 1'b1;
    pdata[2]   = 16'hbeef;
    do_reset();
    pending[2] = 1'b0;

    // Single request on ch1.
    pending[1] = 1'b1;
    pdata[1]   = 16'h1234;
    repeat (7) run_cycle();

    // All channels requesting back-to-back.
    repeat (6) begin
      refill(100);
      run_cycle();
    end
    repeat (8) run_cycle();

    // Move pointer to 2 via a ch1 grant, then ch0+ch3 requests wrap 3 -> 0.
    pending[1] = 1'b1;
    pdata[1]   = W'($urandom);
    repeat (2) run_cycle();
    pending[0] = 1'b1;
    pdata[0]   = W'($urandom);
    pending[3] = 1'b1;
    pdata[3]   = W'($urandom);
    repeat (7) run_cycle();

    // Disable ch1 while its earlier operand is still in flight.
    pending[1] = 1'b1;
    pdata[1]   = W'($urandom);
    run_cycle();
    chan_en    = 4'b1101;
    pending[1] = 1'b1;
    pdata[1]   = W'($urandom);
    repeat (10) run_cycle();
    chan_en = '1;
    repeat (6) run_cycle();

    // Flush with three operands in flight and all channels requesting.
    repeat (3) begin
      refill(100);
      run_cycle();
    end
    refill(100);
    flush = 1'b1;
    run_cycle();
    flush = 1'b0;
    repeat (8) run_cycle();

    // Randomised traffic with channel enables and occasional flushes.
    for (int n = 0; n < 400; n++) begin
      refill(60);
      chan_en = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
      flush   = ($urandom_range(0, 29) == 0);
      run_cycle();
    end
    flush   = 1'b0;
    chan_en = '1;

    // Reset in the middle of a busy stream.
    repeat (3) begin
      refill(100);
      run_cycle();
    end
    do_reset();
    for (int n = 0; n < 20; n++) begin
      if (n < 10) refill(70);
      run_cycle();
    end
    repeat (8) run_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
